// File: rtl/recolector_datos.sv
// recolector_datos: walks regfile then data memory one word per enable_next for the debug UART path.
// Optional RECOLECTOR_CHECKSUM_EN appends an XOR checksum word after the last memory word.
module recolector_datos #(
  parameter int len            = 32,
  parameter int cant_regs      = 32,
  parameter int cant_mem_datos = 16,
  parameter int NB_reg_addr    = $clog2(cant_regs),
  parameter int NB_mem_addr    = $clog2(cant_mem_datos)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   send_regs,
  input  logic                   enable_next,
  output logic [NB_reg_addr-1:0] reg_addr,
  input  logic [len-1:0]         reg_data,
  output logic [NB_mem_addr-1:0] mem_addr,
  output logic                   mem_re,
  input  logic [len-1:0]         mem_data,
  output logic [len-1:0]         data_out,
  output logic                   data_valid,
  output logic                   done
);
`ifdef RECOLECTOR_CHECKSUM_EN
  typedef enum logic [1:0] {S_REGS = 2'd0, S_MEM = 2'd1, S_CSUM = 2'd2, S_DONE = 2'd3} state_t;
  logic [len-1:0] acc;
`else
  typedef enum logic [1:0] {S_REGS = 2'd0, S_MEM = 2'd1, S_DONE = 2'd3} state_t;
`endif
  localparam logic [NB_reg_addr-1:0] LAST_REG = NB_reg_addr'(cant_regs - 1);
  localparam logic [NB_mem_addr-1:0] LAST_MEM = NB_mem_addr'(cant_mem_datos - 1);
  state_t state, next_state;
  logic [1:0] pend;
  logic last_reg, last_mem, to_mem, advance, capture;
  logic [len-1:0] src;
  assign last_reg = reg_addr == LAST_REG;
  assign last_mem = mem_addr == LAST_MEM;
  assign to_mem   = last_reg || !send_regs;
  assign advance  = enable_next && state != S_DONE;
  // an accepted advance re-arms the pipe, so an in-flight word is never captured
  assign capture  = pend[1] && !advance;
  assign src      = state == S_MEM ? mem_data : reg_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_REGS;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (restart) next_state = S_REGS;
    else if (enable_next)
      case (state)
        S_REGS: next_state = to_mem ? S_MEM : S_REGS;
`ifdef RECOLECTOR_CHECKSUM_EN
        S_MEM:  next_state = last_mem ? S_CSUM : S_MEM;
        S_CSUM: next_state = S_DONE;
`else
        S_MEM:  next_state = last_mem ? S_DONE : S_MEM;
`endif
        default: next_state = state;
      endcase
  end
  always_comb begin
    mem_re = state == S_MEM;
    done   = state == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      reg_addr   <= '0;
      mem_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      pend       <= 2'b01;
    end else if (restart) begin
      reg_addr   <= '0;
      mem_addr   <= '0;
      data_valid <= 1'b0;
      pend       <= 2'b01;
    end else if (advance) begin
      data_valid <= 1'b0;
      pend       <= 2'b00;
      if (state == S_REGS) begin
        pend <= 2'b01;
        if (to_mem) mem_addr <= '0;
        else reg_addr <= reg_addr + 1'b1;
      end
      if (state == S_MEM && !last_mem) begin
        pend     <= 2'b01;
        mem_addr <= mem_addr + 1'b1;
      end
`ifdef RECOLECTOR_CHECKSUM_EN
      if (state == S_MEM && last_mem) begin
        data_out   <= acc;
        data_valid <= 1'b1;
      end
`endif
    end else begin
      pend <= {pend[0], 1'b0};
      if (pend[1]) begin
        data_out   <= src;
        data_valid <= 1'b1;
      end
    end
`ifdef RECOLECTOR_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (restart) acc <= '0;
    else if (capture) acc <= acc ^ src;
`endif
endmodule

// File: tb/tb_recolector_datos.sv
// tb_recolector_datos: directed stimulus with a word-sequence/latency model checked every cycle.
module tb_recolector_datos;
  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, send_regs = 1'b1, enable_next = 1'b0;
  logic [4:0] reg_addr;
  logic [3:0] mem_addr;
  logic mem_re, data_valid, done;
  logic [31:0] reg_data = '0, mem_data = '0, data_out;
  logic [31:0] regs [32];
  logic [31:0] mem [16];
  logic rst_q, en_q, restart_q, send_q;
  int errors = 0, checks = 0;
  int ph, ridx, midx, age;
  logic [31:0] last, acc;

  recolector_datos dut (
    .clk(clk), .reset(reset), .restart(restart), .send_regs(send_regs),
    .enable_next(enable_next), .reg_addr(reg_addr), .reg_data(reg_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data),
    .data_out(data_out), .data_valid(data_valid), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    reg_data <= regs[reg_addr];
    if (mem_re) mem_data <= mem[mem_addr];
    rst_q <= reset;
    en_q <= enable_next;
    restart_q <= restart;
    send_q <= send_regs;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word();
    return ph == 0 ? regs[ridx] : mem[midx];
  endfunction

  // model: phase 0 regs, 1 mem, 2 checksum, 3 done; a word is valid two cycles after its address appears
  initial forever begin
    @(negedge clk);
    if (reset || rst_q !== 1'b0) begin
      ph = 0; ridx = 0; midx = 0; age = 0; last = 0; acc = 0;
    end else begin
      if (restart_q) begin
        ph = 0; ridx = 0; midx = 0; age = 0; acc = 0;
      end else if (en_q && ph != 3) begin
        age = 0;
        if (ph == 0) begin
          if (ridx == 31 || !send_q) begin ph = 1; midx = 0; end
          else ridx++;
        end else if (ph == 1) begin
          if (midx == 15) begin
`ifdef RECOLECTOR_CHECKSUM_EN
            ph = 2; last = acc;
`else
            ph = 3;
`endif
          end else midx++;
        end else ph = 3;
      end else if (ph < 2 && age < 2) begin
        age++;
        if (age == 2) begin last = word(); acc ^= last; end
      end
      chk("cyc_data_out", data_out, last);
      chk("cyc_data_valid", {31'b0, data_valid}, {31'b0, (ph < 2 && age == 2) || ph == 2});
      chk("cyc_done", {31'b0, done}, {31'b0, ph == 3});
      chk("cyc_mem_re", {31'b0, mem_re}, {31'b0, ph == 1});
      chk("cyc_reg_addr", {27'b0, reg_addr}, ridx);
      chk("cyc_mem_addr", {28'b0, mem_addr}, midx);
    end
  end

  task automatic pulse(input int gap);
    @(negedge clk) enable_next = 1'b1;
    @(negedge clk) enable_next = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000 + k;
    for (int k = 0; k < 16; k++) mem[k] = 32'hA000 + k;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", {31'b0, data_valid}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mem_re", {31'b0, mem_re}, 0);
    chk("rst_reg_addr", {27'b0, reg_addr}, 0);
    reset = 1'b0;
    @(negedge clk) chk("rel_valid_1", {31'b0, data_valid}, 0);
    @(negedge clk) chk("rel_valid_2", {31'b0, data_valid}, 1);
    chk("reg0", data_out, 32'h1000);
    pulse(0);
    chk("adv_valid_e1", {31'b0, data_valid}, 0);
    @(negedge clk) chk("adv_valid_e2", {31'b0, data_valid}, 0);
    @(negedge clk) chk("adv_valid_e3", {31'b0, data_valid}, 1);
    chk("reg1", data_out, 32'h1001);
    for (int i = 0; i < 30; i++) pulse(3);
    chk("reg31_addr", {27'b0, reg_addr}, 31);
    chk("reg31", data_out, 32'h101F);
    pulse(3);
    chk("mem0_re", {31'b0, mem_re}, 1);
    chk("mem0_addr", {28'b0, mem_addr}, 0);
    chk("mem0", data_out, 32'hA000);
    for (int i = 0; i < 15; i++) pulse(3);
    chk("mem15", data_out, 32'hA00F);
`ifdef RECOLECTOR_CHECKSUM_EN
    pulse(0);
    chk("csum_valid", {31'b0, data_valid}, 1);
    chk("csum", data_out, 32'h0);
    pulse(1);
    chk("end_hold", data_out, 32'h0);
`else
    pulse(1);
    chk("end_hold", data_out, 32'hA00F);
`endif
    chk("end_done", {31'b0, done}, 1);
    chk("end_valid", {31'b0, data_valid}, 0);
    pulse(2);
    chk("done_ignores_next", {31'b0, done}, 1);
    do_restart();
    chk("rs_done", {31'b0, done}, 0);
    chk("rs_reg_addr", {27'b0, reg_addr}, 0);
    repeat (2) @(negedge clk);
    chk("rs_reg0", data_out, 32'h1000);
    for (int i = 0; i < 5; i++) pulse(3);
    chk("reg5", data_out, 32'h1005);
    send_regs = 1'b0;
    pulse(3);
    send_regs = 1'b1;
    chk("skip_mem_re", {31'b0, mem_re}, 1);
    chk("skip_mem_addr", {28'b0, mem_addr}, 0);
    chk("skip_mem0", data_out, 32'hA000);
    for (int i = 0; i < 7; i++) pulse(3);
    chk("mem7", data_out, 32'hA007);
    @(negedge clk) begin restart = 1'b1; enable_next = 1'b1; end
    @(negedge clk) begin restart = 1'b0; enable_next = 1'b0; end
    chk("rsen_reg_addr", {27'b0, reg_addr}, 0);
    chk("rsen_done", {31'b0, done}, 0);
    chk("rsen_mem_re", {31'b0, mem_re}, 0);
    repeat (2) @(negedge clk);
    chk("rsen_reg0", data_out, 32'h1000);
    chk("rsen_valid", {31'b0, data_valid}, 1);
    seen = 1'b0;
    @(negedge clk) enable_next = 1'b1;
    @(negedge clk) enable_next = 1'b1;
    @(negedge clk) enable_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= data_out == 32'h1001;
      @(negedge clk);
    end
    chk("b2b_no_stale", {31'b0, seen}, 0);
    chk("b2b_reg2", data_out, 32'h1002);
    seen = 1'b0;
    @(negedge clk) enable_next = 1'b1;
    @(negedge clk) enable_next = 1'b0;
    @(negedge clk) enable_next = 1'b1;
    @(negedge clk) enable_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= data_out == 32'h1003;
      @(negedge clk);
    end
    chk("gap1_no_stale", {31'b0, seen}, 0);
    chk("gap1_reg4", data_out, 32'h1004);
`ifdef RECOLECTOR_CHECKSUM_EN
    for (int k = 0; k < 32; k++) regs[k] = 32'h1;
    for (int k = 0; k < 16; k++) mem[k] = 32'h1;
    do_restart();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 48; i++) pulse(3);
    chk("ones_csum_valid", {31'b0, data_valid}, 1);
    chk("ones_csum", data_out, 32'h0);
    pulse(1);
    chk("ones_done", {31'b0, done}, 1);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
